// File: rtl/mul_iter_pkg.sv
// Shared definitions for the iterative M-extension multiplier: op encodings,
// FSM states and the per-op operand signedness lookup.
package mul_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Returns {a_is_signed, b_is_signed} for an op.
  function automatic logic [1:0] op_sign_flags(input logic [1:0] op);
    logic [1:0] flags;
    flags = 2'b00;
    case (op)
      MUL_OP_MULH:   flags = 2'b11;
      MUL_OP_MULHSU: flags = 2'b10;
      default:       flags = 2'b00;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/mul_iter_step.sv
// One CALC step: multiply the operand magnitude by a BITS_PER_CYCLE-bit
// multiplier chunk, align it to the chunk position and add it into the accumulator.
module mul_iter_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int IDX_W          = 6
) (
  input  logic [XLEN-1:0]           mag_i,
  input  logic [BITS_PER_CYCLE-1:0] chunk_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic [2*XLEN-1:0]         acc_i,
  output logic [2*XLEN-1:0]         acc_o
);

  localparam int SH_W = $clog2(2 * XLEN) + 1;

  logic [2*XLEN-1:0] mag_ext;
  logic [2*XLEN-1:0] terms [BITS_PER_CYCLE];
  logic [2*XLEN-1:0] chunk_sum;
  logic [SH_W-1:0]   shamt;

  assign mag_ext = {{XLEN{1'b0}}, mag_i};
  assign shamt   = SH_W'(idx_i) * SH_W'(BITS_PER_CYCLE);

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
      assign terms[gi] = chunk_i[gi] ? (mag_ext << gi) : '0;
    end
  endgenerate

  always_comb begin
    chunk_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      chunk_sum = chunk_sum + terms[i];
    end
    acc_o = acc_i + (chunk_sum << shamt);
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative MUL/MULH/MULHSU/MULHU unit with start/busy/done handshake.
// Define MUL_ITER_EARLY_OUT_EN to leave CALC as soon as the remaining multiplier is zero.
module mul_iter
  import mul_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy,
  output logic            o_done
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [2*XLEN-1:0] ACC_ONE = 1;

  generate
    if (XLEN % BITS_PER_CYCLE != 0) begin : g_bad_cfg
      $error("mul_iter: BITS_PER_CYCLE must divide XLEN");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mag_a_q, mag_a_d;
  logic [XLEN-1:0]   mult_q, mult_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mult_shift;
  logic [1:0]        sign_flags;
  logic              sign_a, sign_b, calc_last;

  mul_iter_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .IDX_W          (CNT_W)
  ) u_step (
    .mag_i   (mag_a_q),
    .chunk_i (mult_q[BITS_PER_CYCLE-1:0]),
    .idx_i   (cnt_q),
    .acc_i   (acc_q),
    .acc_o   (acc_step)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    neg_d      = neg_q;
    mag_a_d    = mag_a_q;
    mult_d     = mult_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    result_d   = result_q;
    done_d     = 1'b0;

    sign_flags = op_sign_flags(i_op);
    sign_a     = sign_flags[1] & i_a[XLEN-1];
    sign_b     = sign_flags[0] & i_b[XLEN-1];
    mult_shift = mult_q >> BITS_PER_CYCLE;
    product    = neg_q ? (~acc_q + ACC_ONE) : acc_q;

    calc_last  = (cnt_q == CNT_W'(N - 1));
`ifdef MUL_ITER_EARLY_OUT_EN
    calc_last  = calc_last | (mult_shift == '0);
`endif

    case (state_q)
      IDLE: begin
        if (i_start) begin
          op_d    = i_op;
          // Two's-complement negate yields 2^(XLEN-1) for the most-negative value, which fits unsigned.
          mag_a_d = sign_a ? (~i_a + 1'b1) : i_a;
          mult_d  = sign_b ? (~i_b + 1'b1) : i_b;
          neg_d   = sign_a ^ sign_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_step;
        mult_d = mult_shift;
        cnt_d  = cnt_q + CNT_W'(1);
        if (calc_last) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = (op_q == MUL_OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      op_q     <= MUL_OP_MUL;
      neg_q    <= 1'b0;
      mag_a_q  <= '0;
      mult_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mag_a_q  <= mag_a_d;
      mult_q   <= mult_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_done   = done_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_mul_iter.sv
// Scoreboard bench for mul_iter: driver pushes expected results, a forked monitor
// checks each done pulse. Expected latency follows MUL_ITER_EARLY_OUT_EN when defined.
module tb_mul_iter;
  import mul_pkg::*;

  localparam int XLEN = 32;
  localparam int BPC  = 1;
  localparam int N    = XLEN / BPC;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a, b, result;
  logic            busy, done;

  mul_iter #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_result (result),
    .o_busy   (busy),
    .o_done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] res;
    int              lat;
    int              start_cyc;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference: sign/zero-extend to 2*XLEN and multiply with plain arithmetic.
  function automatic logic [XLEN-1:0] ref_result(input logic [1:0] o, input logic [XLEN-1:0] x,
                                                 input logic [XLEN-1:0] y);
    logic [2*XLEN-1:0] ex, ey, p;
    logic              sx, sy;
    sx = (o == MUL_OP_MULH) || (o == MUL_OP_MULHSU);
    sy = (o == MUL_OP_MULH);
    ex = sx ? {{XLEN{x[XLEN-1]}}, x} : {{XLEN{1'b0}}, x};
    ey = sy ? {{XLEN{y[XLEN-1]}}, y} : {{XLEN{1'b0}}, y};
    p  = ex * ey;
    return (o == MUL_OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [XLEN-1:0] y);
`ifdef MUL_ITER_EARLY_OUT_EN
    logic [XLEN-1:0] mag;
    int              hi;
    mag = ((o == MUL_OP_MULH) && y[XLEN-1]) ? (~y + 1'b1) : y;
    hi  = -1;
    for (int i = 0; i < XLEN; i++) if (mag[i]) hi = i;
    if (hi < 0) return 2;
    return (hi + BPC) / BPC + 1;
`else
    return N + 1;
`endif
  endfunction

  task automatic monitor();
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: o_done=1 result=%08h, required no done pulse", result);
        end else begin
          e   = sb_q.pop_front();
          lat = cyc - e.start_cyc;
          n_tests++;
          if (result !== e.res) begin
            n_fail++;
            $display("FAIL result op=%0d a=%08h b=%08h: got %08h, required %08h", e.op, e.a, e.b, result, e.res);
          end
          n_tests++;
          if (lat != e.lat) begin
            n_fail++;
            $display("FAIL latency op=%0d b=%08h: got %0d, required %0d", e.op, e.b, lat, e.lat);
          end
          n_tests++;
          if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_at_done: got %b, required 0", busy);
          end
          $display("[TB] op=%0d a=%08h b=%08h -> %08h lat=%0d", e.op, e.a, e.b, result, lat);
        end
      end
    end
  endtask

  // Issue one op (callable in the done cycle for back-to-back) and wait for its done.
  task automatic issue(input logic [1:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       input logic [XLEN-1:0] exp_res, input bit glitch);
    exp_t e;
    bit   got;
    start = 1'b1; op = o; a = x; b = y;
    e.res = exp_res; e.lat = ref_latency(o, y); e.start_cyc = cyc + 1;
    e.op = o; e.a = x; e.b = y;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b, required 1", busy);
    end
    got = 1'b0;
    for (int k = 0; k < N + 20; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = glitch && (k == 5);
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: o_done=%b, required 1 within %0d cycles", done, N + 20);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      sb_q.delete();
    end
  endtask

  initial begin
    logic [1:0]      ro;
    logic [XLEN-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    fork monitor(); join_none
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b result=%08h, required 0 0 00000000", busy, done, result);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    issue(MUL_OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    issue(MUL_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    issue(MUL_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    issue(MUL_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue(MUL_OP_MULHSU, 32'd2,        32'h80000000, 32'h00000001, 1'b0);
    issue(MUL_OP_MUL,    32'd5,        32'd1,        32'd5,        1'b0);
    issue(MUL_OP_MULHU,  32'h12345678, 32'hFEDCBA98, ref_result(MUL_OP_MULHU, 32'h12345678, 32'hFEDCBA98), 1'b1);

    // Abort an op in flight with reset around CALC cycle 10.
    @(posedge clk); #1;
    start = 1'b1; op = MUL_OP_MULHU; a = 32'hDEADBEEF; b = 32'hF0000000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b done=%b result=%08h, required 0 0 00000000", busy, done, result);
    end
    repeat (N + 5) @(posedge clk);
    #1;

    issue(MUL_OP_MULH, 32'hFFFFFFF9, 32'd6, 32'hFFFFFFFF, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      case ($urandom_range(0, 4))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = 32'h80000000;
        2:       rb = $urandom >> $urandom_range(1, 31);
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb, ref_result(ro, ra, rb), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
